// File: rtl/cw305_usb_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : cw305_usb_bus_master
//  Description : Host-side initiator for the CW305 parallel USB register bus.
//                Turns command/stream transactions into address/data/strobe
//                cycles with burst auto-increment, read latency handling and
//                read-to-write bus turnaround.
//  Revision    : 1.0 - initial release
// ============================================================================
module cw305_usb_bus_master #(
   parameter int pADDR_WIDTH   = 21,
   parameter int pBYTECNT_SIZE = 7,
   parameter int pRD_LATENCY   = 2,
   parameter int pTURNAROUND   = 4
) (
   input  logic                     usb_clk,
   input  logic                     rst_n,
   // command interface
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_write,
   input  logic [pADDR_WIDTH-1:0]   cmd_addr,
   input  logic [pBYTECNT_SIZE-1:0] cmd_len,
   // write stream
   input  logic [7:0]               wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   // read stream
   output logic [7:0]               rd_data,
   output logic                     rd_valid,
   output logic                     rd_last,
   output logic                     busy,
   // register bus
   output logic [pADDR_WIDTH-1:0]   bus_addr,
   output logic [7:0]               bus_dout,
   output logic                     bus_doe,
   input  logic [7:0]               bus_din,
   output logic                     bus_rdn,
   output logic                     bus_wrn,
   output logic                     bus_cen,
   output logic                     bus_alen
);

   // one counter times both the read wait and the turnaround
   localparam int c_CNT_MAX = (pRD_LATENCY > pTURNAROUND) ? pRD_LATENCY : pTURNAROUND;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
   localparam logic [c_CNT_W-1:0] c_RD_LAST   = c_CNT_W'(pRD_LATENCY - 1);
   localparam logic [c_CNT_W-1:0] c_TURN_LAST = c_CNT_W'(pTURNAROUND - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_HOLD   = 3'd3,
      S_WAIT   = 3'd4,
      S_TURN   = 3'd5
   } state_t;

   state_t                   r_state;
   state_t                   w_next_state;

   logic                     r_write;
   logic [pBYTECNT_SIZE-1:0] r_len;
   logic [pBYTECNT_SIZE-1:0] r_index;
   logic [c_CNT_W-1:0]       r_cnt;

   logic                     r_cmd_ready;
   logic                     r_busy;
   logic                     r_rd_valid;
   logic                     r_rd_last;
   logic [7:0]               r_rd_data;
   logic [pADDR_WIDTH-1:0]   r_bus_addr;
   logic [7:0]               r_bus_dout;
   logic                     r_bus_doe;
   logic                     r_bus_rdn;
   logic                     r_bus_wrn;
   logic                     r_bus_cen;

   logic                     w_accept;
   logic                     w_wr_take;
   logic                     w_last_byte;
   logic                     w_wait_done;
   logic                     w_turn_done;
   logic                     w_next_byte;
   logic                     w_cen_n;
   logic                     w_rdn_n;
   logic                     w_wrn_n;
   logic                     w_doe;

   assign w_accept    = cmd_valid & r_cmd_ready;
   // the byte is consumed only in a write SETUP cycle with data offered
   assign w_wr_take   = rst_n & (r_state == S_SETUP) & r_write & wr_valid;
   assign w_last_byte = (r_index == r_len);
   assign w_wait_done = (r_cnt == c_RD_LAST);
   assign w_turn_done = (r_cnt == c_TURN_LAST);
   assign w_next_byte = ((r_state == S_HOLD) || (r_state == S_WAIT)) && (w_next_state == S_SETUP);

   // next-state decode plus the values the registered bus strobes take next
   always_comb begin
      w_next_state = r_state;
      w_cen_n      = 1'b1;
      w_rdn_n      = 1'b1;
      w_wrn_n      = 1'b1;
      w_doe        = 1'b0;
      case (r_state)
         S_IDLE:   if (w_accept) w_next_state = S_SETUP;
         S_SETUP:  if (!r_write || wr_valid) w_next_state = S_STROBE;
         S_STROBE: w_next_state = r_write ? S_HOLD : S_WAIT;
         S_HOLD:   w_next_state = w_last_byte ? S_IDLE : S_SETUP;
         S_WAIT:   if (w_wait_done) w_next_state = w_last_byte ? S_TURN : S_SETUP;
         S_TURN:   if (w_turn_done) w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
      // strobes follow the state being entered so they appear registered
      case (w_next_state)
         S_SETUP, S_STROBE, S_HOLD, S_WAIT: w_cen_n = 1'b0;
         default:                           w_cen_n = 1'b1;
      endcase
      if (w_next_state == S_STROBE) begin
         w_wrn_n = ~r_write;
         w_rdn_n = r_write;
      end
      // data bus is driven only around a write strobe, never in read states
      w_doe = r_write && ((w_next_state == S_STROBE) || (w_next_state == S_HOLD));
   end

   // state register
   always_ff @(posedge usb_clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // burst bookkeeping, registered bus outputs and read return path
   always_ff @(posedge usb_clk) begin
      if (!rst_n) begin
         r_write     <= 1'b0;
         r_len       <= '0;
         r_index     <= '0;
         r_cnt       <= '0;
         r_cmd_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_last   <= 1'b0;
         r_rd_data   <= 8'h00;
         r_bus_addr  <= '0;
         r_bus_dout  <= 8'h00;
         r_bus_doe   <= 1'b0;
         r_bus_rdn   <= 1'b1;
         r_bus_wrn   <= 1'b1;
         r_bus_cen   <= 1'b1;
      end else begin
         // counter restarts on every state change
         r_cnt <= (w_next_state != r_state) ? '0 : r_cnt + 1'b1;
         if (w_accept) begin
            r_write    <= cmd_write;
            r_len      <= cmd_len;
            r_index    <= '0;
            r_bus_addr <= cmd_addr;
         end else if (w_next_byte) begin
            // low field wraps inside the byte window; upper field never changes
            r_index <= r_index + 1'b1;
            r_bus_addr[pBYTECNT_SIZE-1:0] <= r_bus_addr[pBYTECNT_SIZE-1:0] + 1'b1;
         end
         if (w_wr_take) r_bus_dout <= wr_data;
         r_bus_cen   <= w_cen_n;
         r_bus_rdn   <= w_rdn_n;
         r_bus_wrn   <= w_wrn_n;
         r_bus_doe   <= w_doe;
         r_cmd_ready <= (w_next_state == S_IDLE);
         r_busy      <= (w_next_state != S_IDLE);
         // target data is valid at the end of the last wait cycle
         r_rd_valid  <= (r_state == S_WAIT) && w_wait_done;
         r_rd_last   <= (r_state == S_WAIT) && w_wait_done && w_last_byte;
         if ((r_state == S_WAIT) && w_wait_done) r_rd_data <= bus_din;
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign wr_ready  = w_wr_take;
   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign rd_last   = r_rd_last;
   assign busy      = r_busy;
   assign bus_addr  = r_bus_addr;
   assign bus_dout  = r_bus_dout;
   assign bus_doe   = r_bus_doe;
   assign bus_rdn   = r_bus_rdn;
   assign bus_wrn   = r_bus_wrn;
   assign bus_cen   = r_bus_cen;
   // address-latch mode is not used by this bus
   assign bus_alen  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_cw305_usb_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cw305_usb_bus_master
//  Description : Scoreboard bench for cw305_usb_bus_master with a simple
//                register target model (write capture, addr-low-byte reads).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cw305_usb_bus_master;

   logic        usb_clk   = 1'b0;
   logic        rst_n     = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [20:0] cmd_addr  = '0;
   logic [6:0]  cmd_len   = '0;
   logic [7:0]  wr_data   = 8'h00;
   logic        wr_valid  = 1'b0;
   logic        wr_ready;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_last;
   logic        busy;
   logic [20:0] bus_addr;
   logic [7:0]  bus_dout;
   logic        bus_doe;
   logic [7:0]  bus_din   = 8'h00;
   logic        bus_rdn;
   logic        bus_wrn;
   logic        bus_cen;
   logic        bus_alen;

   cw305_usb_bus_master dut (
      .usb_clk  (usb_clk),
      .rst_n    (rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_len  (cmd_len),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_last  (rd_last),
      .busy     (busy),
      .bus_addr (bus_addr),
      .bus_dout (bus_dout),
      .bus_doe  (bus_doe),
      .bus_din  (bus_din),
      .bus_rdn  (bus_rdn),
      .bus_wrn  (bus_wrn),
      .bus_cen  (bus_cen),
      .bus_alen (bus_alen)
   );

   always #5 usb_clk = ~usb_clk;

   int cyc = 0;
   always @(posedge usb_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // scoreboards: expected target writes and expected read returns
   logic [20:0] wq_addr[$];
   logic [7:0]  wq_data[$];
   logic [7:0]  rq_data[$];
   logic        rq_last[$];

   // write-stream source: byte plus number of idle cycles before offering it
   logic [7:0]  drv_data[$];
   int          drv_gap[$];
   bit          take;

   // observation statistics
   int wrn_pulses, setup_cycles, rdv_count;
   int first_wrn, last_wrn, first_rdv, last_rd, doe_rise;
   int viol = 0, overlap = 0, isout_cnt = 0;
   bit tgt_wr_pend = 1'b0, doe_prev = 1'b0;

   task automatic clear_stats();
      wrn_pulses = 0; setup_cycles = 0; rdv_count = 0;
      first_wrn = -1; last_wrn = -1; first_rdv = -1; last_rd = -1; doe_rise = -1;
   endtask

   // write data driver
   always begin
      @(negedge usb_clk);
      take = wr_valid && wr_ready;
      @(posedge usb_clk);
      #1;
      if (take && drv_data.size() != 0) begin
         void'(drv_data.pop_front());
         void'(drv_gap.pop_front());
      end
      if (drv_data.size() == 0) begin
         wr_valid = 1'b0;
      end else if (drv_gap[0] > 0) begin
         wr_valid   = 1'b0;
         drv_gap[0] = drv_gap[0] - 1;
      end else begin
         wr_valid = 1'b1;
         wr_data  = drv_data[0];
      end
   end

   // target model and bus monitor, evaluated mid-cycle
   always @(negedge usb_clk) begin
      if (!bus_rdn && !bus_wrn) viol++;
      if ((!bus_rdn || !bus_wrn) && bus_cen) viol++;
      if (bus_doe && isout_cnt != 0) overlap++;
      if (!bus_wrn) begin
         wrn_pulses++;
         if (first_wrn < 0) first_wrn = cyc;
         last_wrn = cyc;
         check("strobe_doe", 32'(bus_doe), 32'd1);
      end
      if (bus_doe && !doe_prev && doe_rise < 0) doe_rise = cyc;
      doe_prev = bus_doe;
      if (!bus_cen && bus_wrn && bus_rdn && !bus_doe) setup_cycles++;
      // target registers the write strobe and samples din the cycle after
      if (tgt_wr_pend) begin
         check("wr_expected", 32'(wq_addr.size() != 0), 32'd1);
         check("hold_doe", 32'(bus_doe), 32'd1);
         if (wq_addr.size() != 0) begin
            check("wr_addr", 32'(bus_addr), 32'(wq_addr.pop_front()));
            check("wr_data", 32'(bus_dout), 32'(wq_data.pop_front()));
         end
      end
      tgt_wr_pend = !bus_wrn;
      // read target returns the address low byte and drives for two cycles
      if (!bus_rdn) begin
         bus_din   = bus_addr[7:0];
         isout_cnt = 2;
      end else if (isout_cnt > 0) begin
         isout_cnt--;
      end
      if (rd_valid) begin
         rdv_count++;
         if (first_rdv < 0) first_rdv = cyc;
         if (rd_last) last_rd = cyc;
         check("rd_expected", 32'(rq_data.size() != 0), 32'd1);
         if (rq_data.size() != 0) begin
            check("rd_data", 32'(rd_data), 32'(rq_data.pop_front()));
            check("rd_last", 32'(rd_last), 32'(rq_last.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge usb_clk);
      #1;
   endtask

   task automatic issue_cmd(input logic wr, input logic [20:0] addr, input logic [6:0] len,
                            output int acc);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_len   = len;
      while (!cmd_ready && n < 100) begin
         tick();
         n++;
      end
      check("cmd_accept", 32'(cmd_ready), 32'd1);
      acc = cyc;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || !cmd_ready) && n < 200) begin
         tick();
         n++;
      end
      check("idle_reached", 32'(busy), 32'd0);
   endtask

   task automatic push_write(input logic [20:0] addr, input logic [7:0] data, input int gap);
      drv_data.push_back(data);
      drv_gap.push_back(gap);
      wq_addr.push_back(addr);
      wq_data.push_back(data);
   endtask

   task automatic push_read(input logic [7:0] data, input logic last);
      rq_data.push_back(data);
      rq_last.push_back(last);
   endtask

   // stimulus sequence
   initial begin
      int acc, acc_w;
      logic [20:0] wrap_addr[4];
      clear_stats();
      repeat (3) tick();
      check("rst_strobes", 32'({bus_cen, bus_rdn, bus_wrn, bus_alen}), 32'hF);
      check("rst_addr", 32'(bus_addr), 32'd0);
      check("rst_dout", 32'({bus_dout, bus_doe}), 32'd0);
      check("rst_handshake", 32'({cmd_ready, wr_ready, busy}), 32'd0);
      check("rst_read", 32'({rd_data, rd_valid, rd_last}), 32'd0);
      rst_n = 1'b1;
      tick();
      check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

      // single write byte
      clear_stats();
      push_write(21'h000100, 8'hA5, 0);
      issue_cmd(1'b1, 21'h000100, 7'd0, acc);
      wait_idle();
      check("t1_wrn_pulses", 32'(wrn_pulses), 32'd1);
      check("t1_wrn_latency", 32'(first_wrn - acc), 32'd2);

      // four-byte read burst
      clear_stats();
      for (int i = 0; i < 4; i++) push_read(8'(i), i == 3);
      issue_cmd(1'b0, 21'h000200, 7'd3, acc);
      wait_idle();
      check("t2_rd_count", 32'(rdv_count), 32'd4);
      check("t2_first_rd", 32'(first_rdv - acc), 32'd5);
      check("t2_last_rd", 32'(last_rd - acc), 32'd17);

      // write burst wrapping the byte window
      clear_stats();
      wrap_addr = '{21'h00017E, 21'h00017F, 21'h000100, 21'h000101};
      for (int i = 0; i < 4; i++) push_write(wrap_addr[i], 8'(8'h11 * (i + 1)), 0);
      issue_cmd(1'b1, 21'h00017E, 7'd3, acc);
      wait_idle();
      check("t3_wrn_pulses", 32'(wrn_pulses), 32'd4);
      check("t3_last_wrn", 32'(last_wrn - acc), 32'd11);
      check("t3_setup_cycles", 32'(setup_cycles), 32'd4);

      // wr_valid dropped for five cycles before the third byte; two of those
      // overlap the previous byte's strobe/hold, leaving three stall cycles
      clear_stats();
      for (int i = 0; i < 4; i++) push_write(21'h000040 + 21'(i), 8'(8'hC0 + i), (i == 2) ? 5 : 0);
      issue_cmd(1'b1, 21'h000040, 7'd3, acc);
      wait_idle();
      check("t4_wrn_pulses", 32'(wrn_pulses), 32'd4);
      check("t4_setup_cycles", 32'(setup_cycles), 32'd7);
      check("t4_last_wrn", 32'(last_wrn - acc), 32'd14);

      // read followed immediately by a write: turnaround gap
      clear_stats();
      push_read(8'h10, 1'b0);
      push_read(8'h11, 1'b1);
      push_write(21'h000220, 8'h5A, 0);
      issue_cmd(1'b0, 21'h000210, 7'd1, acc);
      issue_cmd(1'b1, 21'h000220, 7'd0, acc_w);
      wait_idle();
      check("t5_last_rd", 32'(last_rd - acc), 32'd9);
      check("t5_turn_accept", 32'(acc_w - last_rd), 32'd4);
      check("t5_doe_rise", 32'(doe_rise - last_rd), 32'd6);

      // reset while waiting for read data
      clear_stats();
      push_read(8'h00, 1'b1);
      issue_cmd(1'b0, 21'h000300, 7'd0, acc);
      tick();
      tick();
      check("t6_in_wait", 32'({bus_cen, bus_rdn}), 32'b01);
      rst_n = 1'b0;
      tick();
      check("t6_strobes", 32'({bus_cen, bus_rdn, bus_wrn}), 32'b111);
      check("t6_rst_idle", 32'({cmd_ready, busy}), 32'd0);
      rq_data.delete();
      rq_last.delete();
      rst_n = 1'b1;
      tick();
      check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (6) tick();
      check("t6_no_rd_valid", 32'(rdv_count), 32'd0);

      // global invariants and leftovers
      check("wq_empty", 32'(wq_addr.size()), 32'd0);
      check("rq_empty", 32'(rq_data.size()), 32'd0);
      check("strobe_violations", 32'(viol), 32'd0);
      check("doe_isout_overlap", 32'(overlap), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/cw305_usb_bus_master.md
# cw305_usb_bus_master

Host-side initiator for the CW305 parallel USB register bus: converts a simple command/stream interface into the address/data/strobe cycles that the FPGA register front-end expects (registered inputs, one-cycle read latency, output-enable tail). Used in loopback/self-test builds and in bench harnesses to drive a target register block with bus-accurate timing. Handles multi-byte bursts with byte-count auto-increment and enforces read-to-write bus turnaround.

## Interface
Parameters:
- pADDR_WIDTH, 21, full bus address width
- pBYTECNT_SIZE, 7, width of byte-index field (low address bits)
- pRD_LATENCY, 2, cycles from rdn-low cycle to read-data sample cycle
- pTURNAROUND, 4, idle cycles after a read before bus_doe may assert

Ports:
- usb_clk  in  1  sole clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  pADDR_WIDTH  start address
- cmd_len  in  pBYTECNT_SIZE  burst length minus one (0 = 1 byte)
- wr_data  in  8  write byte
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  wr_data consumed this cycle
- rd_data  out  8  read byte
- rd_valid  out  1  one-cycle pulse per read byte
- rd_last  out  1  qualifies final rd_valid of burst
- busy  out  1  high from accept to end of turnaround
- bus_addr  out  pADDR_WIDTH  to target usb_addr
- bus_dout  out  8  to target usb_din
- bus_doe  out  1  master drives data bus
- bus_din  in  8  from target usb_dout
- bus_rdn, bus_wrn, bus_cen, bus_alen  out  1 each  active-low strobes (alen held high)

## Operation
- States: IDLE, SETUP, STROBE, HOLD (write), WAIT (read), TURN.
- IDLE: cmd_ready=1 only when not in TURN; on accept latch cmd_write, cmd_addr, cmd_len; index=0; go SETUP.
- SETUP: bus_cen=0, bus_addr=current address. Write: if wr_valid, wr_ready=1 for that cycle, latch byte to bus_dout, bus_doe=1, go STROBE; else stall in SETUP (strobes high). Read: go STROBE.
- STROBE: one cycle of bus_wrn=0 (write) or bus_rdn=0 (read). Write → HOLD; read → WAIT.
- HOLD: wrn=1, addr/dout/doe held one cycle (target samples din unregistered one cycle after strobe). Next: SETUP of next byte or end.
- WAIT: rdn=1, addr held for pRD_LATENCY cycles counted from STROBE; bus_din sampled at the edge ending cycle STROBE+pRD_LATENCY; rd_valid pulses the following cycle.
- Address: upper field [pADDR_WIDTH-1:pBYTECNT_SIZE] constant for the burst; low field = cmd_addr low + index, modulo 2^pBYTECNT_SIZE (wraps, never carries into upper field).
- End of write burst → IDLE with cen=1, doe=0. End of read burst → TURN for pTURNAROUND cycles (cen=1, doe=0, cmd_ready=0), then IDLE.
- bus_doe is never 1 in any read state or TURN.

## Timing
- All bus outputs registered. Reset (rst_n low at an edge): cen=rdn=wrn=alen=1, addr=0, dout=0, doe=0, cmd_ready=0, wr_ready=0, rd_valid=0, rd_last=0, busy=0, rd_data=0, state IDLE; cmd_ready=1 first cycle after release.
- Reset mid-burst: strobes high at next edge, burst abandoned, no further wr_ready/rd_valid.
- Write: 3 cycles/byte with no stalls; accept at cycle A → first wrn low at A+2; cen low continuous across burst.
- Read: 2+pRD_LATENCY cycles/byte (4 default); rdn low at A+2, first rd_valid at A+5.
- Only one of rdn/wrn low in any cycle; never low while cen high.

## Test plan
- Write 1 byte 0xA5 to addr 0x000100 → exactly one cycle wrn=0; addr=0x000100, dout=0xA5, doe=1 during STROBE and HOLD; target reg_write sees 0xA5 once.
- Read burst len=3 from 0x000200 against model returning addr low byte → rd_data 0x00,0x01,0x02,0x03, rd_last on fourth, first rd_valid 5 cycles after accept.
- Write burst starting 0x00017E, len=3 → bus_addr 0x17E,0x17F,0x100,0x101 (wrap, upper field 0x002 unchanged).
- Write with wr_valid low 5 cycles mid-burst → stays in SETUP, strobes high, no duplicate/missing bytes.
- Read then write back-to-back → cmd_ready low and doe=0 for 4 cycles after last read WAIT; target isout and bus_doe never both high.
- rst_n low during read WAIT → next cycle all strobes high, no rd_valid, cmd_ready=1 after release.
